// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline register chain.
package pipe_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int DEF_W       = 64;
  localparam int DEF_AW      = 3;

  typedef struct packed {
    logic              valid;
    logic              wb;
    logic [DEF_AW-1:0] dst;
    logic              is_load;
    logic [DEF_W-1:0]  data;
  } stage_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: hold keeps contents, bubble clears valid, flush overrides both.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int W  = 64,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          hold_i,
  input  logic          bubble_i,
  input  logic          flush_i,
  input  logic          valid_i,
  input  logic          wb_i,
  input  logic          is_load_i,
  input  logic [AW-1:0] dst_i,
  input  logic [W-1:0]  data_i,
  output logic          valid_o,
  output logic          wb_o,
  output logic          is_load_o,
  output logic [AW-1:0] dst_o,
  output logic [W-1:0]  data_o
);

  logic          valid_q, valid_d;
  logic          wb_q, wb_d;
  logic          isLoad_q, isLoad_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [W-1:0]  data_q, data_d;

  // A bubble only drops valid; payload fields of a dead stage are left alone.
  always_comb begin
    valid_d  = valid_q;
    wb_d     = wb_q;
    isLoad_d = isLoad_q;
    dst_d    = dst_q;
    data_d   = data_q;
    if (!hold_i) begin
      if (bubble_i) begin
        valid_d = 1'b0;
      end else begin
        valid_d  = valid_i;
        wb_d     = wb_i;
        isLoad_d = is_load_i;
        dst_d    = dst_i;
        data_d   = data_i;
      end
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      wb_q     <= 1'b0;
      isLoad_q <= 1'b0;
      dst_q    <= '0;
      data_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      wb_q     <= wb_d;
      isLoad_q <= isLoad_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign wb_o      = wb_q;
  assign is_load_o = isLoad_q;
  assign dst_o     = dst_q;
  assign data_o    = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// Pipeline register chain with stall back-propagation, per-stage flush and load-use interlock.
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = 4,
  parameter int W      = 64,
  parameter int AW     = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [W-1:0]           in_data,
  input  logic                   in_wb,
  input  logic [AW-1:0]          in_dst,
  input  logic                   in_is_load,
  input  logic [AW-1:0]          in_src_a,
  input  logic [AW-1:0]          in_src_b,
  input  logic                   in_use_a,
  input  logic                   in_use_b,
  input  logic [STAGES-1:0]      stall_i,
  input  logic [STAGES-1:0]      flush_i,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [W-1:0]           out_data,
  output logic [STAGES-1:0]      stage_valid,
  output logic [STAGES*AW-1:0]   stage_dst,
  output logic [STAGES-1:0]      stage_wb,
  output logic                   load_use,
  input  logic                   cnt_clr,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic [STAGES-1:0] holdVec;
  logic [STAGES-1:0] bubbleVec;
  logic [STAGES-1:0] upValid, upWb, upLoad;
  logic [W-1:0]      upData [STAGES];
  logic [AW-1:0]     upDst  [STAGES];
  logic [STAGES-1:0] stValid, stWb, stLoad;
  logic [W-1:0]      stData [STAGES];
  logic [AW-1:0]     stDst  [STAGES];
  logic              outBlock;
  logic              loadUse;
  logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

  // A stage holds if it or anything downstream stalls; invalid stages do not absorb it.
  always_comb begin
    outBlock = stValid[STAGES-1] & ~out_ready;
    holdVec  = '0;
    for (int k = 0; k < STAGES; k++) begin
      holdVec[k] = (|(stall_i >> k)) | outBlock;
    end
  end

  assign loadUse = in_valid & stValid[0] & stLoad[0] & stWb[0] &
                   ((in_use_a & (in_src_a == stDst[0])) |
                    (in_use_b & (in_src_b == stDst[0])));

  for (genvar g = 0; g < STAGES; g++) begin : gStage
    if (g == 0) begin : gHead
      assign upValid[g]   = in_valid & ~loadUse;
      assign upWb[g]      = in_wb;
      assign upLoad[g]    = in_is_load;
      assign upDst[g]     = in_dst;
      assign upData[g]    = in_data;
      assign bubbleVec[g] = 1'b0;
    end else begin : gBody
      assign upValid[g]   = stValid[g-1];
      assign upWb[g]      = stWb[g-1];
      assign upLoad[g]    = stLoad[g-1];
      assign upDst[g]     = stDst[g-1];
      assign upData[g]    = stData[g-1];
      assign bubbleVec[g] = holdVec[g-1];
    end

    pipe_stage_reg #(.W(W), .AW(AW)) uReg (
      .clk       (clk),
      .rst       (rst),
      .hold_i    (holdVec[g]),
      .bubble_i  (bubbleVec[g]),
      .flush_i   (flush_i[g]),
      .valid_i   (upValid[g]),
      .wb_i      (upWb[g]),
      .is_load_i (upLoad[g]),
      .dst_i     (upDst[g]),
      .data_i    (upData[g]),
      .valid_o   (stValid[g]),
      .wb_o      (stWb[g]),
      .is_load_o (stLoad[g]),
      .dst_o     (stDst[g]),
      .data_o    (stData[g])
    );

    assign stage_dst[g*AW +: AW] = stDst[g];
  end

  // Clear takes priority so software can restart measurement on any cycle.
  always_comb begin
    stallCnt_d = stallCnt_q;
    if (cnt_clr) begin
      stallCnt_d = '0;
    end else if (in_valid & ~in_ready) begin
      stallCnt_d = sat_inc(stallCnt_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) stallCnt_q <= '0;
    else      stallCnt_q <= stallCnt_d;
  end

  assign in_ready    = ~holdVec[0] & ~loadUse;
  assign load_use    = loadUse;
  assign out_valid   = stValid[STAGES-1];
  assign out_data    = stData[STAGES-1];
  assign stage_valid = stValid;
  assign stage_wb    = stWb & stValid;
  assign stall_cnt   = stallCnt_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench: directed table, hand sequences and random traffic against a stage-array model.
module tb_pipe_stage_chain;

  localparam int S  = 4;
  localparam int W  = 64;
  localparam int AW = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid, in_ready, in_wb, in_is_load, in_use_a, in_use_b;
  logic [W-1:0]   in_data;
  logic [AW-1:0]  in_dst, in_src_a, in_src_b;
  logic [S-1:0]   stall_i, flush_i;
  logic           out_ready, out_valid, load_use, cnt_clr;
  logic [W-1:0]   out_data;
  logic [S-1:0]   stage_valid, stage_wb;
  logic [S*AW-1:0] stage_dst;
  logic [15:0]    stall_cnt;

  int checks = 0;
  int errors = 0;
  bit doCheck = 1'b1;

  // Reference model: one record per stage, updated by the textual stage rules.
  bit            mv   [S];
  bit            mwb  [S];
  bit            mld  [S];
  logic [AW-1:0] mdst [S];
  logic [W-1:0]  md   [S];
  int            mcnt;
  bit            mhold [S];
  bit            mlu, mready;

  always #5 clk = ~clk;

  pipe_stage_chain #(.STAGES(S), .W(W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_wb(in_wb), .in_dst(in_dst), .in_is_load(in_is_load), .in_src_a(in_src_a),
    .in_src_b(in_src_b), .in_use_a(in_use_a), .in_use_b(in_use_b), .stall_i(stall_i),
    .flush_i(flush_i), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .stage_valid(stage_valid), .stage_dst(stage_dst), .stage_wb(stage_wb),
    .load_use(load_use), .cnt_clr(cnt_clr), .stall_cnt(stall_cnt)
  );

  task automatic checkEq(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < S; k++) begin
      mv[k] = 0; mwb[k] = 0; mld[k] = 0; mdst[k] = '0; md[k] = '0;
    end
    mcnt = 0;
  endtask

  task automatic evalModel();
    bit blocked;
    blocked = mv[S-1] && !out_ready;
    for (int k = S-1; k >= 0; k--) begin
      blocked  = blocked || stall_i[k];
      mhold[k] = blocked;
    end
    mlu = in_valid && mv[0] && mld[0] && mwb[0] &&
          ((in_use_a && in_src_a == mdst[0]) || (in_use_b && in_src_b == mdst[0]));
    mready = !mhold[0] && !mlu;
  endtask

  task automatic settle();
    logic [S-1:0] ev, ew;
    #1;
    evalModel();
    if (doCheck) begin
      for (int k = 0; k < S; k++) begin
        ev[k] = mv[k];
        ew[k] = mv[k] && mwb[k];
      end
      checkEq("out_valid", out_valid, mv[S-1]);
      if (mv[S-1]) checkEq("out_data", out_data, md[S-1]);
      checkEq("in_ready", in_ready, mready);
      checkEq("load_use", load_use, mlu);
      checkEq("stage_valid", stage_valid, ev);
      checkEq("stage_wb", stage_wb, ew);
      for (int k = 0; k < S; k++)
        if (mv[k]) checkEq("stage_dst", stage_dst[k*AW +: AW], mdst[k]);
      checkEq("stall_cnt", stall_cnt, mcnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int k = S-1; k >= 1; k--) begin
        if (mhold[k]) begin
        end else if (mhold[k-1]) begin
          mv[k] = 0;
        end else begin
          mv[k] = mv[k-1]; mwb[k] = mwb[k-1]; mld[k] = mld[k-1];
          mdst[k] = mdst[k-1]; md[k] = md[k-1];
        end
      end
      if (!mhold[0]) begin
        mv[0] = in_valid && !mlu; mwb[0] = in_wb; mld[0] = in_is_load;
        mdst[0] = in_dst; md[0] = in_data;
      end
      for (int k = 0; k < S; k++) if (flush_i[k]) mv[k] = 0;
      if (cnt_clr) mcnt = 0;
      else if (in_valid && !mready) mcnt = (mcnt < 65535) ? mcnt + 1 : 65535;
    end
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit v, input logic [W-1:0] d, input bit wb,
                               input logic [AW-1:0] dst, input bit ld,
                               input logic [AW-1:0] sa, input bit ua);
    in_valid = v; in_data = d; in_wb = wb; in_dst = dst; in_is_load = ld;
    in_src_a = sa; in_use_a = ua; in_src_b = '0; in_use_b = 1'b0;
  endtask

  task automatic idleInputs();
    applyStimulus(0, '0, 0, '0, 0, '0, 0);
    stall_i = '0; flush_i = '0; out_ready = 1'b1; cnt_clr = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkEq(name, act, exp);
  endtask

  typedef struct {
    bit          inV;
    logic [63:0] data;
    bit          expOV;
    logic [63:0] expOD;
    bit          expReady;
  } vec_t;

  vec_t tbl [12];

  initial begin
    for (int c = 0; c < 12; c++) begin
      tbl[c].inV      = (c < 8);
      tbl[c].data     = 64'(c + 1);
      tbl[c].expOV    = (c >= 4);
      tbl[c].expOD    = (c >= 4) ? 64'(c - 3) : 64'd0;
      tbl[c].expReady = 1'b1;
    end

    idleInputs();
    modelReset();
    @(negedge clk);
    settle();
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_stage_valid", stage_valid, 0);
    checkOutput("rst_stage_dst", stage_dst, 0);
    checkOutput("rst_stage_wb", stage_wb, 0);
    checkOutput("rst_stall_cnt", stall_cnt, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b1;

    // Full-rate stream of 1..8.
    for (int c = 0; c < 12; c++) begin
      applyStimulus(tbl[c].inV, tbl[c].data, 0, '0, 0, '0, 0);
      settle();
      checkOutput("tbl_out_valid", out_valid, tbl[c].expOV);
      if (tbl[c].expOV) checkOutput("tbl_out_data", out_data, tbl[c].expOD);
      checkOutput("tbl_in_ready", in_ready, tbl[c].expReady);
      tick();
    end
    idleInputs();
    settle();
    checkOutput("stream_stall_cnt", stall_cnt, 0);
    tick();

    // Load-use: exactly one interlock cycle.
    applyStimulus(1, 64'd100, 1, 3'd3, 1, '0, 0); settle(); tick();
    applyStimulus(1, 64'd101, 0, 3'd0, 0, 3'd3, 1); settle();
    checkOutput("lu_active", load_use, 1);
    checkOutput("lu_in_ready", in_ready, 0);
    tick();
    settle();
    checkOutput("lu_cleared", load_use, 0);
    checkOutput("lu_ready_back", in_ready, 1);
    checkOutput("lu_bubble_s0", stage_valid[0], 0);
    checkOutput("lu_load_s1", stage_valid[1], 1);
    checkOutput("lu_stall_cnt", stall_cnt, 1);
    tick();
    applyStimulus(1, 64'd102, 1, 3'd3, 1, '0, 0); settle(); tick();
    applyStimulus(1, 64'd103, 0, 3'd0, 0, 3'd3, 0); settle();
    checkOutput("nolu_active", load_use, 0);
    checkOutput("nolu_in_ready", in_ready, 1);
    tick();
    idleInputs();
    for (int i = 0; i < 5; i++) begin settle(); tick(); end
    checkOutput("nolu_stall_cnt", stall_cnt, 1);

    // Fill, then stall stage 1 for two cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 64'(200 + i), 0, 3'(i), 0, '0, 0); settle(); tick();
    end
    applyStimulus(1, 64'd204, 0, 3'd4, 0, '0, 0);
    stall_i = 4'b0010;
    settle(); checkOutput("st1_in_ready", in_ready, 0); tick();
    settle(); checkOutput("st1_valid_a", stage_valid, 4'b1011); tick();
    stall_i = '0;
    settle();
    checkOutput("st1_valid_b", stage_valid, 4'b0011);
    checkOutput("st1_stall_cnt", stall_cnt, 3);
    tick();

    // Output back-pressure for three cycles.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 64'(300 + i), 1, 3'(i + 1), 0, '0, 0); settle(); tick();
    end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      checkOutput("bp_in_ready", in_ready, 0);
      checkOutput("bp_full", stage_valid, 4'b1111);
      tick();
    end
    out_ready = 1'b1;
    idleInputs();
    for (int i = 0; i < 6; i++) begin settle(); tick(); end

    // Flush stages 0,1 while stage 0 is stalled.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 64'(400 + i), 0, 3'(i), 0, '0, 0); settle(); tick();
    end
    stall_i = 4'b0001; flush_i = 4'b0011;
    settle(); tick();
    stall_i = '0; flush_i = '0;
    settle();
    checkOutput("flush_valid", stage_valid, 4'b1100);
    tick();

    // Async reset mid-stream.
    applyStimulus(1, 64'd500, 1, 3'd5, 0, '0, 0);
    settle(); tick();
    settle();
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_stage_valid", stage_valid, 0);
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_stall_cnt", stall_cnt, 0);
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    settle(); tick();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom),
                    3'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 3)), 1'($urandom));
      in_src_b  = 3'($urandom_range(0, 3));
      in_use_b  = 1'($urandom);
      stall_i   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      flush_i   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clr   = ($urandom_range(0, 49) == 0);
      settle(); tick();
    end

    // Counter saturation and clear.
    idleInputs();
    applyStimulus(1, 64'd600, 0, '0, 0, '0, 0);
    out_ready = 1'b0;
    doCheck = 1'b0;
    for (int i = 0; i < 65600; i++) begin settle(); tick(); end
    doCheck = 1'b1;
    settle(); checkOutput("sat_value", stall_cnt, 16'hFFFF); tick();
    settle(); checkOutput("sat_hold", stall_cnt, 16'hFFFF);
    tick();
    cnt_clr = 1'b1; settle(); tick();
    cnt_clr = 1'b0; settle();
    checkOutput("clr_value", stall_cnt, 0);
    tick();
    settle(); checkOutput("clr_recount", stall_cnt, 1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
